ternary_mac_sequencer: RTL and testbench

Controller that sequences the 1-cycle registered ternary select stage to compute one TAPS-long ternary dot product.
- Loads TAPS 2-bit ternary weights over a weight stream.
- Streams TAPS features through the select stage, one weight per feature.
- Accumulates the signed select results and presents the sum on a valid/ready result port.
- Sits between the feature buffer and the next layer's input in the TNN accelerator.

---
 rtl/ternary_mac_sequencer_pkg.sv | 22 ++
 rtl/ternary_mac_sequencer_if.sv | 45 ++++
 rtl/ternary_mac_sequencer_acc.sv | 68 ++++++
 rtl/ternary_mac_sequencer.sv | 111 +++++++++++
 tb/tb_ternary_mac_sequencer.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ternary_mac_sequencer_pkg.sv
// Shared state encoding, ternary kernel codes and default widths for the TNN control slice.
// Optional saturation (TERNARY_MAC_SATURATE_EN) is handled in ternary_acc; nothing here depends on it.
package tnn_ctrl_pkg;

   localparam int unsigned DEF_FEATURE_WIDTH = 32;
   localparam int unsigned DEF_KERNEL_WIDTH  = 2;
   localparam int unsigned DEF_TAPS          = 9;
   localparam int unsigned DEF_ACC_WIDTH     = 40;

   localparam logic [1:0] K_POS  = 2'b01;
   localparam logic [1:0] K_NEG  = 2'b11;
   localparam logic [1:0] K_ZERO = 2'b00;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_W,
      RUN,
      DRAIN,
      DONE
   } state_t;

endpackage

// File: rtl/ternary_mac_sequencer_if.sv
// Handshake/bus bundle for ternary_mac_sequencer: control, weight/feature streams, select-stage link, result port.
// sat_flag exists only when TERNARY_MAC_SATURATE_EN is defined.
interface ternary_mac_sequencer_if
   import tnn_ctrl_pkg::*;
#(
   parameter int unsigned FEATURE_WIDTH = DEF_FEATURE_WIDTH,
   parameter int unsigned KERNEL_WIDTH  = DEF_KERNEL_WIDTH,
   parameter int unsigned ACC_WIDTH     = DEF_ACC_WIDTH
);

   logic                     start;
   logic                     busy;
   logic                     w_valid;
   logic [KERNEL_WIDTH-1:0]  w_data;
   logic                     w_ready;
   logic                     f_valid;
   logic [FEATURE_WIDTH-1:0] f_data;
   logic                     f_ready;
   logic [FEATURE_WIDTH-1:0] sel_feature;
   logic [KERNEL_WIDTH-1:0]  sel_kernel;
   logic [FEATURE_WIDTH-1:0] sel_result;
   logic                     res_valid;
   logic [ACC_WIDTH-1:0]     res_data;
   logic                     res_ready;
`ifdef TERNARY_MAC_SATURATE_EN
   logic                     sat_flag;
`endif

   modport slave (
      input  start, w_valid, w_data, f_valid, f_data, sel_result, res_ready,
      output busy, w_ready, f_ready, sel_feature, sel_kernel, res_valid, res_data
`ifdef TERNARY_MAC_SATURATE_EN
      , output sat_flag
`endif
   );

   modport master (
      output start, w_valid, w_data, f_valid, f_data, sel_result, res_ready,
      input  busy, w_ready, f_ready, sel_feature, sel_kernel, res_valid, res_data
`ifdef TERNARY_MAC_SATURATE_EN
      , input sat_flag
`endif
   );

endinterface

// File: rtl/ternary_mac_sequencer_acc.sv
// ternary_acc: signed accumulator fed by the select stage; wraps at ACC_WIDTH, or clamps with a
// sticky sat flag when TERNARY_MAC_SATURATE_EN is defined.
module ternary_acc
   import tnn_ctrl_pkg::*;
#(
   parameter int unsigned FEATURE_WIDTH = DEF_FEATURE_WIDTH,
   parameter int unsigned ACC_WIDTH     = DEF_ACC_WIDTH
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            i_clear,
   input  logic                            i_en,
   input  logic signed [FEATURE_WIDTH-1:0] i_addend,
`ifdef TERNARY_MAC_SATURATE_EN
   input  logic                            i_sat_clear,
   output logic                            o_sat,
`endif
   output logic signed [ACC_WIDTH-1:0]     o_acc
);

   logic signed [ACC_WIDTH:0]   w_sum;
   logic signed [ACC_WIDTH-1:0] w_next;
   logic signed [ACC_WIDTH-1:0] r_acc;

   // One guard bit so overflow shows up as disagreement of the top two bits.
   assign w_sum = (ACC_WIDTH+1)'(r_acc) + (ACC_WIDTH+1)'(i_addend);

`ifdef TERNARY_MAC_SATURATE_EN
   logic w_ovf;
   logic r_sat;

   always_comb begin
      w_ovf  = w_sum[ACC_WIDTH] != w_sum[ACC_WIDTH-1];
      w_next = w_sum[ACC_WIDTH-1:0];
      if (w_ovf) begin
         w_next = w_sum[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sat <= 1'b0;
      end else if (i_sat_clear) begin
         r_sat <= 1'b0;
      end else if (i_en && w_ovf) begin
         r_sat <= 1'b1;
      end
   end

   assign o_sat = r_sat;
`else
   assign w_next = w_sum[ACC_WIDTH-1:0];
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc <= '0;
      end else if (i_clear) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= w_next;
      end
   end

   assign o_acc = r_acc;

endmodule

// File: rtl/ternary_mac_sequencer.sv
// Sequences an external 1-cycle registered ternary select stage over TAPS weight/feature pairs
// and returns the dot product. Build with TERNARY_MAC_SATURATE_EN for clamping plus sat_flag.
module ternary_mac_sequencer
   import tnn_ctrl_pkg::*;
#(
   parameter int unsigned FEATURE_WIDTH = DEF_FEATURE_WIDTH,
   parameter int unsigned KERNEL_WIDTH  = DEF_KERNEL_WIDTH,
   parameter int unsigned TAPS          = DEF_TAPS,
   parameter int unsigned ACC_WIDTH     = DEF_ACC_WIDTH
) (
   input logic                    clk,
   input logic                    rst_n,
   ternary_mac_sequencer_if.slave bus
);

   localparam int unsigned     TAP_W    = (TAPS > 1) ? $clog2(TAPS) : 1;
   localparam logic [TAP_W-1:0] LAST_TAP = TAP_W'(TAPS - 1);

   state_t                  r_state, w_state_nxt;
   logic [TAP_W-1:0]        r_tap, w_tap_nxt;
   logic [KERNEL_WIDTH-1:0] r_weight [TAPS];
   logic                    r_pend;

   logic                        w_w_acc;
   logic                        w_issue;
   logic                        w_res_hs;
   logic                        w_load_done;
   logic signed [ACC_WIDTH-1:0] w_acc;

   assign w_w_acc     = bus.w_valid && (r_state == LOAD_W);
   assign w_issue     = bus.f_valid && (r_state == RUN);
   assign w_res_hs    = bus.res_ready && (r_state == DONE);
   assign w_load_done = w_w_acc && (r_tap == LAST_TAP);

   always_comb begin
      w_state_nxt     = r_state;
      w_tap_nxt       = r_tap;
      bus.busy        = (r_state != IDLE);
      bus.w_ready     = (r_state == LOAD_W);
      bus.f_ready     = (r_state == RUN);
      bus.res_valid   = (r_state == DONE);
      bus.res_data    = '0;
      bus.sel_feature = '0;
      bus.sel_kernel  = '0;

      case (r_state)
         IDLE: begin
            if (bus.start) begin
               w_state_nxt = LOAD_W;
               w_tap_nxt   = '0;
            end
         end
         LOAD_W: begin
            if (w_w_acc) begin
               w_tap_nxt = w_load_done ? '0 : r_tap + 1'b1;
               if (w_load_done) w_state_nxt = RUN;
            end
         end
         RUN: begin
            // Idle cycles drive zeros so the stage emits 0 and nothing is ever double-counted.
            if (w_issue) begin
               bus.sel_feature = bus.f_data;
               bus.sel_kernel  = r_weight[r_tap];
               w_tap_nxt       = (r_tap == LAST_TAP) ? '0 : r_tap + 1'b1;
               if (r_tap == LAST_TAP) w_state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            w_state_nxt = DONE;
         end
         DONE: begin
            bus.res_data = w_acc;
            if (w_res_hs) w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_tap   <= '0;
         r_pend  <= 1'b0;
         for (int unsigned i = 0; i < TAPS; i++) r_weight[i] <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_tap   <= w_tap_nxt;
         r_pend  <= w_issue;
         if (w_w_acc) r_weight[r_tap] <= bus.w_data;
      end
   end

   ternary_acc #(
      .FEATURE_WIDTH (FEATURE_WIDTH),
      .ACC_WIDTH     (ACC_WIDTH)
   ) u_acc (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_clear     (w_load_done),
      .i_en        (r_pend),
      .i_addend    (bus.sel_result),
`ifdef TERNARY_MAC_SATURATE_EN
      .i_sat_clear (w_res_hs),
      .o_sat       (bus.sat_flag),
`endif
      .o_acc       (w_acc)
   );

endmodule

// File: tb/tb_ternary_mac_sequencer.sv
// Randomized self-checking bench for ternary_mac_sequencer (TAPS=3, ACC_WIDTH=33) with a registered
// select-stage model and an arithmetic dot-product reference; honours TERNARY_MAC_SATURATE_EN.
module tb_ternary_mac_sequencer;

   localparam int unsigned FW   = 32;
   localparam int unsigned KW   = 2;
   localparam int unsigned TAPS = 3;
   localparam int unsigned AW   = 33;

   localparam longint MAXV = (longint'(1) <<< (AW - 1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (AW - 1));

   logic clk;
   logic rst_n;

   ternary_mac_sequencer_if #(
      .FEATURE_WIDTH (FW),
      .KERNEL_WIDTH  (KW),
      .ACC_WIDTH     (AW)
   ) bus ();

   ternary_mac_sequencer #(
      .FEATURE_WIDTH (FW),
      .KERNEL_WIDTH  (KW),
      .TAPS          (TAPS),
      .ACC_WIDTH     (AW)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External select stage: one registered cycle, +f / -f (wrapping at FW) / 0.
   logic [FW-1:0] sel_r;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sel_r <= '0;
      else if (bus.sel_kernel == 2'b01) sel_r <= bus.sel_feature;
      else if (bus.sel_kernel == 2'b11) sel_r <= -bus.sel_feature;
      else sel_r <= '0;
   end
   assign bus.sel_result = sel_r;

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   logic [1:0] ws [TAPS];
   int         fs [TAPS];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void model(output logic [AW-1:0] r, output bit sat);
      longint acc;
      int     p;
      acc = 0;
      sat = 1'b0;
      for (int i = 0; i < int'(TAPS); i++) begin
         case (ws[i])
            2'b01:   p = fs[i];
            2'b11:   p = -fs[i];
            default: p = 0;
         endcase
         acc += longint'(p);
`ifdef TERNARY_MAC_SATURATE_EN
         if (acc > MAXV) begin acc = MAXV; sat = 1'b1; end
         else if (acc < MINV) begin acc = MINV; sat = 1'b1; end
`endif
      end
      r = acc[AW-1:0];
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_busy"},      64'(bus.busy),        64'd0);
      chk({tag, "_w_ready"},   64'(bus.w_ready),     64'd0);
      chk({tag, "_f_ready"},   64'(bus.f_ready),     64'd0);
      chk({tag, "_sel_feat"},  64'(bus.sel_feature), 64'd0);
      chk({tag, "_sel_kern"},  64'(bus.sel_kernel),  64'd0);
      chk({tag, "_res_valid"}, 64'(bus.res_valid),   64'd0);
      chk({tag, "_res_data"},  64'(bus.res_data),    64'd0);
`ifdef TERNARY_MAC_SATURATE_EN
      chk({tag, "_sat_flag"},  64'(bus.sat_flag),    64'd0);
`endif
   endtask

   task automatic run_op(input int gap, input int bp, input bit rnd_w, input int abort_at);
      logic [AW-1:0] exp_r;
      bit            exp_s;
      int            wi, fi, gcnt, cyc;
      model(exp_r, exp_s);
      wi = 0; fi = 0; gcnt = 0;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      cyc = 1;
      chk("busy_after_start", 64'(bus.busy), 64'd1);
      while (!bus.res_valid && cyc < 500) begin
         bus.w_valid = (wi < int'(TAPS)) && (!rnd_w || $urandom_range(3) != 0);
         bus.w_data  = (wi < int'(TAPS)) ? ws[wi] : 2'b00;
         bus.f_valid = (fi < int'(TAPS)) && (gcnt == 0);
         bus.f_data  = (fi < int'(TAPS)) ? fs[fi] : 0;
         if (bus.w_valid && bus.w_ready) wi++;
         if (bus.f_ready) begin
            if (bus.f_valid) begin fi++; gcnt = gap; end
            else if (gcnt > 0) gcnt--;
         end
         @(negedge clk);
         cyc++;
         if (abort_at > 0 && fi == abort_at) begin
            rst_n = 1'b0;
            #1;
            check_reset_outputs("mid_run_reset");
            @(negedge clk);
            bus.w_valid = 1'b0;
            bus.f_valid = 1'b0;
            rst_n = 1'b1;
            @(negedge clk);
            chk("idle_after_reset", 64'(bus.busy), 64'd0);
            return;
         end
      end
      bus.w_valid = 1'b0;
      bus.f_valid = 1'b0;
      chk("res_valid_seen", 64'(bus.res_valid), 64'd1);
      if (!bus.res_valid) return;
      if (gap == 0 && !rnd_w) chk("latency", 64'(cyc), 64'(2 * TAPS + 2));
      for (int b = 0; b < bp; b++) begin
         bus.start = 1'b1;
         chk("hold_res_data",  64'(bus.res_data),  64'(exp_r));
         chk("hold_res_valid", 64'(bus.res_valid), 64'd1);
         chk("hold_f_ready",   64'(bus.f_ready),   64'd0);
         @(negedge clk);
      end
      chk("res_data", 64'(bus.res_data), 64'(exp_r));
`ifdef TERNARY_MAC_SATURATE_EN
      chk("sat_flag", 64'(bus.sat_flag), 64'(exp_s));
`endif
      bus.res_ready = 1'b1;
      @(negedge clk);
      bus.res_ready = 1'b0;
      bus.start     = 1'b0;
      chk("hs_busy",      64'(bus.busy),      64'd0);
      chk("hs_res_valid", 64'(bus.res_valid), 64'd0);
`ifdef TERNARY_MAC_SATURATE_EN
      chk("hs_sat_clear", 64'(bus.sat_flag),  64'd0);
`endif
      @(negedge clk);
      chk("start_in_done_ignored", 64'(bus.busy), 64'd0);
   endtask

   task automatic set_vec(input logic [1:0] w0, w1, w2, input int f0, f1, f2);
      ws[0] = w0; ws[1] = w1; ws[2] = w2;
      fs[0] = f0; fs[1] = f1; fs[2] = f2;
   endtask

   initial begin
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.w_valid   = 1'b0;
      bus.w_data    = '0;
      bus.f_valid   = 1'b0;
      bus.f_data    = '0;
      bus.res_ready = 1'b0;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      set_vec(2'b01, 2'b11, 2'b00, 5, 7, 100);
      run_op(0, 0, 1'b0, 0);
      run_op(2, 0, 1'b0, 0);
      run_op(0, 5, 1'b0, 0);

      set_vec(2'b11, 2'b01, 2'b11, 40, -3, 17);
      run_op(0, 0, 1'b0, 2);
      set_vec(2'b01, 2'b01, 2'b11, 12, -30, 8);
      run_op(0, 0, 1'b0, 0);

      set_vec(2'b10, 2'b01, 2'b01, 9, 1, 2);
      run_op(0, 0, 1'b0, 0);

      set_vec(2'b01, 2'b01, 2'b01, 32'h7fff_ffff, 32'h7fff_ffff, 32'h7fff_ffff);
      run_op(0, 1, 1'b0, 0);

      set_vec(2'b11, 2'b11, 2'b01, 32'h8000_0000, 32'h8000_0000, 32'h8000_0000);
      run_op(1, 0, 1'b0, 0);

      for (int n = 0; n < 25; n++) begin
         for (int i = 0; i < int'(TAPS); i++) begin
            ws[i] = 2'($urandom_range(3));
            fs[i] = (n % 2 == 0) ? int'($urandom) : int'($urandom_range(200)) - 100;
         end
         run_op(int'($urandom_range(2)), int'($urandom_range(3)), 1'($urandom_range(1)), 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
